// File: rtl/lvds_link_pkg.sv
// Shared framing constants and arbiter state type for the LVDS transmit path.
package lvds_link_pkg;

  localparam int FRM_VALID_BIT = 31;
  localparam int FRM_CH_MSB    = 30;
  localparam int FRM_CH_LSB    = 28;
  localparam int FRM_PAYLOAD_W = 28;
  localparam int CH_W          = 3;

  typedef enum logic {ARB, HOLD} arb_state_e;

endpackage

// File: rtl/lvds_rr_pick.sv
// Rotating priority encoder: first asserted request scanning last+1, last+2, ... modulo NUM_CH.
module lvds_rr_pick
  import lvds_link_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [7:0]      req_pad;
  logic [CH_W-1:0] cand;

  always_comb begin
    req_pad = 8'(req);
    idx     = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last) + k) % NUM_CH);
      if (!any && req_pad[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_tx_arb.sv
// Round-robin arbiter framing source FIFO payloads onto the LVDS transmit RDY/EN interface.
// Optional build macro LVDS_ARB_PRIO0_EN: channel 0 wins unconditionally without disturbing rotation.
module lvds_tx_arb
  import lvds_link_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                            tx_inclock,
  input  logic                            reset_n,
  input  logic                            link_up,
  input  logic [NUM_CH*FRM_PAYLOAD_W-1:0] src_data,
  input  logic [NUM_CH-1:0]               src_rdy,
  output logic [NUM_CH-1:0]               src_en,
  output logic [31:0]                     enq_data,
  output logic                            enq_rdy,
  input  logic                            enq_en,
  output logic [CH_W-1:0]                 grant_ch,
  output logic [15:0]                     sent_cnt
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  arb_state_e               state_q, state_d;
  logic [CH_W-1:0]          last_q, last_d, grant_q, pick_ch, rr_idx;
  logic [3:0]               burst_q, burst_d;
  logic [7:0]               rdy_pad;
  logic [FRM_PAYLOAD_W-1:0] payload;
  logic [31:0]              data_q;
  logic [15:0]              cnt_q;
  logic                     rdy_q, rr_any, cont, go, take;

  lvds_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req  (src_rdy),
    .last (last_q),
    .idx  (rr_idx),
    .any  (rr_any)
  );

  // burst_q == 0 means no channel has been granted yet, so rotation starts at last+1
  always_comb begin
    rdy_pad = 8'(src_rdy);
    cont    = (burst_q != 4'd0) && rdy_pad[last_q] && (burst_q < BMAX);
    pick_ch = cont ? last_q : rr_idx;
    last_d  = pick_ch;
    burst_d = burst_q;
    if (cont)
      burst_d = burst_q + 4'd1;
    else if ((rr_idx != last_q) || (burst_q == 4'd0))
      burst_d = 4'd1;
`ifdef LVDS_ARB_PRIO0_EN
    if (src_rdy[0]) begin
      pick_ch = '0;
      last_d  = last_q;
      burst_d = burst_q;
    end
`endif
    payload = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (pick_ch == CH_W'(i)) payload = src_data[FRM_PAYLOAD_W*i +: FRM_PAYLOAD_W];
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    take    = 1'b0;
    case (state_q)
      ARB: if (reset_n && link_up && rr_any) begin
        go      = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (enq_en && rdy_q) begin
        take    = 1'b1;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    src_en = go ? (NUM_CH'(1) << pick_ch) : '0;
  end

  // Holding register stage: word, channel and offer flag become visible the cycle after the pop
  always_ff @(posedge tx_inclock) begin
    if (!reset_n) begin
      state_q <= ARB;
      last_q  <= CH_W'(NUM_CH - 1);
      burst_q <= '0;
      data_q  <= '0;
      grant_q <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == HOLD) && link_up;
      if (go) begin
        data_q  <= {1'b1, pick_ch, payload};
        grant_q <= pick_ch;
        last_q  <= last_d;
        burst_q <= burst_d;
      end
      if (take) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign enq_data = data_q;
  assign enq_rdy  = rdy_q;
  assign grant_ch = grant_q;
  assign sent_cnt = cnt_q;

endmodule

// File: doc/lvds_tx_arb.md
# lvds_tx_arb

Round-robin arbiter that shares the single 32-bit LVDS transmit word interface among up to 8 local source FIFOs. It pops one 28-bit payload at a time from a granted source and frames it as {valid, channel, payload}. It then presents the framed word on the same RDY/EN pull interface that the LVDS transmit FSM already consumes. It sits between the source FIFOs and the LVDS transmit FSM in the tx_inclock domain.

## Interface
- NUM_CH, 4, number of sources; legal 2..8
- BURST_MAX, 4, max consecutive words granted to one source before rotating; legal 1..15
- tx_inclock  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- link_up  in  1  far-end receiver aligned and ready (tx_align_done); gates all grants
- src_data  in  NUM_CH*28  payload per source; channel i at [28*i+27:28*i]; first-word-fall-through
- src_rdy  in  NUM_CH  source i non-empty
- src_en  out  NUM_CH  one-cycle pop pulse, one-hot or zero
- enq_data  out  32  framed word to LVDS transmit FSM
- enq_rdy  out  1  enq_data valid and may be taken
- enq_en  in  1  LVDS transmit FSM takes enq_data this cycle
- grant_ch  out  3  channel of the word in the holding register
- sent_cnt  out  16  words consumed, wraps at 0xFFFF->0

## Operation
- Frame: enq_data = {1'b1, ch[2:0], payload[27:0]}. Bit 31 is always 1 for a real word because the receiver only enqueues words with bit 31 set. Unused channel codes never appear.
- FSM states:
  - ARB: if link_up and |src_rdy, pick ch, pulse src_en[ch], capture src_data[ch] into the holding register, and go to HOLD. Otherwise stay in ARB.
  - HOLD: hold the word. On enq_en & enq_rdy, increment sent_cnt and go to ARB.
- Pick rule:
  - Continue the same ch if src_rdy[last] and burst_cnt < BURST_MAX.
  - Otherwise use the first asserted src_rdy scanning last+1, last+2, ... modulo NUM_CH.
  - burst_cnt resets to 1 on a change of channel and increments on a repeat.
- enq_rdy is registered: 1 in HOLD while link_up, 0 otherwise. enq_en with enq_rdy=0 is ignored.
- link_up falling in HOLD: the word is retained and enq_rdy drops the next cycle. The word is re-offered when link_up returns; it is never dropped or duplicated.
- src_rdy deasserting for an uncaptured channel has no effect. The captured word is already owned by the arbiter.
- Reset values:
  - src_en 0, enq_data 0, enq_rdy 0, grant_ch 0, sent_cnt 0.
  - state ARB, last = NUM_CH-1 (channel 0 wins first), burst_cnt 0.
- Reset mid-HOLD discards the held word. The source has already popped it, which is accepted loss.

## Timing
- Pop to offer: src_en[ch] is high in cycle N and enq_rdy is high in cycle N+1.
- Take to next pop: enq_en in cycle M, state ARB in M+1, next src_en no earlier than M+1, next enq_rdy no earlier than M+2.
- Peak throughput is 1 word / 2 cycles. The LVDS transmit FSM consumes at most 1 word / 4 cycles, so the link is never starved by the arbiter.
- src_en is never asserted in two consecutive cycles.
- sent_cnt updates the cycle after enq_en.

## Configuration
- LVDS_ARB_PRIO0_EN defined:
  - In ARB, src_rdy[0] wins unconditionally.
  - A ch0 grant updates neither last nor burst_cnt, so round-robin among channels 1..NUM_CH-1 resumes where it left off.
- Undefined: channel 0 is an ordinary round-robin participant.

## Structure
- Package lvds_link_pkg holds:
  - frame constants FRM_VALID_BIT=31, FRM_CH_MSB=30, FRM_CH_LSB=28, FRM_PAYLOAD_W=28
  - CH_W=3
  - the arb state enum {ARB, HOLD}
- Sub-module lvds_rr_pick: combinational rotating priority encoder (req, last, returns idx and any). It is the only natural split; burst and priority logic stay in lvds_tx_arb.

## Test plan
- Reset, then link_up=1 and src_rdy=4'b0001 with src_data[0]=28'h0ABCDEF.
  - src_en=0001 one cycle.
  - Next cycle enq_rdy=1, enq_data=32'h80ABCDEF, grant_ch=0.
  - After enq_en, sent_cnt=1.
- All four sources always ready, BURST_MAX=4, enq_en held high: grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
- BURST_MAX=1, src_rdy=4'b1010: alternating grants 1,3,1,3; enq_data[30:28] matches.
- link_up low during HOLD for 10 cycles:
  - enq_rdy=0 throughout and enq_data unchanged.
  - After link_up=1, same word offered once and sent_cnt increments once.
- LVDS_ARB_PRIO0_EN defined, all ready, BURST_MAX=2: every ARB grants ch0. With src_rdy[0] then dropped, the sequence continues 1,1,2,2,3,3.
- 65536 words consumed: sent_cnt wraps to 0. reset_n low mid-HOLD: next cycle enq_rdy=0, src_en=0, sent_cnt=0.
